ks_stream_subtractor: RTL
=========================

# ks_stream_subtractor

Streaming multi-word unsigned/two's-complement subtractor that computes A − B on operands wider than one word. Words arrive least-significant first over a valid/ready handshake, and the borrow is chained between words. Each word difference comes from a Kogge-Stone prefix adder computing A + ~B + carry-in. Results leave through one registered output stage, with end-of-operand flags for the compare and branch logic downstream.

## Interface
- BW, 32, word width in bits (≥ 2)
- clk  in  1  clock, rising edge
- resetn  in  1  reset, asynchronous, active-low
- in_valid  in  1  input word valid
- in_ready  out  1  block accepts input word this cycle
- in_a  in  BW  minuend word
- in_b  in  BW  subtrahend word
- in_first  in  1  word is least-significant word of operand
- in_last  in  1  word is most-significant word of operand
- out_valid  out  1  output word valid
- out_ready  in  1  downstream accepts output word
- out_diff  out  BW  difference word
- out_last  out  1  word is most-significant difference word
- out_borrow  out  1  final borrow (A < B unsigned); meaningful only with out_last
- out_ovf  out  1  signed overflow of full-width result; only with out_last
- out_zero  out  1  entire difference is zero; only with out_last
- err  out  1  sticky protocol error; cleared only by reset

## Operation
- Accept when in_valid & in_ready. in_ready = !out_valid | out_ready, so the block works in the same cycle the output drains.
- Word arithmetic: {c, d} = in_a + ~in_b + cin.
  - cin = 1 when the word is first in its operand; otherwise cin = ~borrow_q.
  - On accept: borrow_q ← ~c and out_diff ← d, both captured.
- A word is first when in_first = 1, or when the FSM is in IDLE.
- FSM states: IDLE (no operand open) and BUSY (operand open).
  - IDLE → BUSY on an accepted word with in_last = 0.
  - BUSY → IDLE on an accepted word with in_last = 1.
  - A single-word operand (in_first = in_last = 1) stays in IDLE.
- Protocol errors set err:
  - a word accepted in IDLE with in_first = 0. The word is still processed as first (cin = 1).
  - a word accepted in BUSY with in_first = 1. The open operand is abandoned and the chain restarts with cin = 1. The abandoned partial result words already emitted are not recalled.
- zero_q tracks whether all difference words so far are zero.
  - It is set to (d == 0) on the first word and updated as zero_q & (d == 0) on later words.
  - out_zero = that value, registered with the last word.
- out_ovf on the last word = (a[BW-1] ^ b[BW-1]) & (a[BW-1] ^ d[BW-1]).
- out_borrow, out_ovf and out_zero are 0 on non-last words.
- Reset values: out_valid 0, out_diff 0, out_last 0, out_borrow 0, out_ovf 0, out_zero 0, err 0, FSM IDLE, borrow_q 0, zero_q 0.
- in_ready is combinational and therefore 1 during reset.

## Timing
- Latency is 1 cycle: a word accepted at edge N is presented on the output after edge N, in the cycle before edge N+1.
- Throughput is one word per cycle when out_ready = 1.
- Stall: while out_valid & !out_ready, the following hold steady:
  - all output registers, borrow_q, zero_q and the FSM hold;
  - in_ready = 0.
- Output payload must not change while out_valid & !out_ready.
- Output drain and new input accept in the same cycle are both legal; the new word overwrites the output register.
- Reset mid-operand discards the open operand and any pending output. The next word is treated as first.
- Combinational path per word is the log2(BW)-level prefix tree, plus the cin injection level and the output register.

## Structure
- Shared package ks_pkg holds:
  - BW_DEFAULT = 32;
  - the FSM state enum {S_IDLE, S_BUSY};
  - a function for the prefix level count, ceil(log2(BW)).
- One sub-module: ks_prefix_add.
  - Parameter BW. Inputs x[BW], y[BW], cin. Outputs s[BW], cout.
  - Purely combinational Kogge-Stone tree with generate/propagate cells.
  - It is instantiated once, with y = ~in_b.
- The top level holds the handshake, FSM, borrow/zero chaining, flags and output register.

## Test plan
All scenarios run with BW = 8.
- Single word: a = 0x05, b = 0x03, first = last = 1 → diff 0x02, borrow 0, ovf 0, zero 0; err stays 0.
- Two words: 0x0100 − 0x0001, LSW first (0x00 − 0x01, then 0x01 − 0x00) → diff words 0xFF then 0x00. Last word has borrow 0 and zero 0.
- Underflow: 0x0000 − 0x0001 over two words → diff words 0xFF then 0xFF, last has borrow 1. Equal operands 0x1234 − 0x1234 → 0x00, 0x00, last has zero 1.
- Signed overflow, single word: 0x80 − 0x01 → diff 0x7F, ovf 1, borrow 0. 0x7F − 0xFF → diff 0x80, ovf 1, borrow 1.
- Backpressure: out_ready held 0 for 3 cycles mid-stream of a 3-word operand → in_ready 0 and output stable for those cycles. After release, all words are delivered in order with correct borrow chaining and no loss or duplication.
- Errors and reset:
  - in_first = 1 while BUSY → err 1 and the new operand computes correctly from cin = 1.
  - resetn pulsed mid-operand → all outputs 0 and FSM IDLE. The next single word 0x09 − 0x04 → 0x05.

Source files
------------

// File: rtl/ks_stream_subtractor_pkg.sv
// Shared definitions for the streaming multi-word subtractor.
//   BW_DEFAULT : default word width
//   state_t    : operand FSM state (S_IDLE = no operand open, S_BUSY = open)
//   ks_levels  : number of Kogge-Stone prefix levels, ceil(log2(bw))
package ks_pkg;

  localparam int BW_DEFAULT = 32;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  function automatic int ks_levels(input int bw);
    int l;
    l = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < bw) l = i + 1;
    end
    return l;
  endfunction

endpackage

// File: rtl/ks_stream_subtractor_if.sv
// Stream interface of the subtractor: input word channel and output word
// channel, both valid/ready.
//
// Handshake: a word moves on a channel at a rising clk edge where valid and
// ready are both 1. The sender keeps valid and payload stable until that edge;
// ready may change freely and is never a function of valid on the receiver
// side except where noted (in_ready = !out_valid | out_ready).
//
//   slave  : the subtractor side (consumes in_*, produces out_*)
//   master : the environment side (produces in_*, consumes out_*)
interface ks_stream_subtractor_if #(
  parameter int BW = ks_pkg::BW_DEFAULT
);
  logic          in_valid;
  logic          in_ready;
  logic [BW-1:0] in_a;
  logic [BW-1:0] in_b;
  logic          in_first;
  logic          in_last;
  logic          out_valid;
  logic          out_ready;
  logic [BW-1:0] out_diff;
  logic          out_last;
  logic          out_borrow;
  logic          out_ovf;
  logic          out_zero;

  modport slave (
    input  in_valid, in_a, in_b, in_first, in_last, out_ready,
    output in_ready, out_valid, out_diff, out_last, out_borrow, out_ovf,
           out_zero
  );

  modport master (
    output in_valid, in_a, in_b, in_first, in_last, out_ready,
    input  in_ready, out_valid, out_diff, out_last, out_borrow, out_ovf,
           out_zero
  );
endinterface

// File: rtl/ks_stream_subtractor_prefix_add.sv
// ks_prefix_add: combinational Kogge-Stone adder, {cout, s} = x + y + cin.
//   x, y : addend words (BW bits)
//   cin  : carry in
//   s    : sum word
//   cout : carry out of the top bit
// The carry-in is folded into the bit-0 generate term so the prefix tree
// directly yields the carry out of every bit position.
module ks_prefix_add
  import ks_pkg::*;
#(
  parameter int BW = BW_DEFAULT
) (
  input  logic [BW-1:0] x,
  input  logic [BW-1:0] y,
  input  logic          cin,
  output logic [BW-1:0] s,
  output logic          cout
);

  localparam int LV = ks_levels(BW);

  logic [BW-1:0] g0;
  logic [BW-1:0] p0;
  logic [BW-1:0] gg;
  logic [BW-1:0] pp;
  logic [BW-1:0] gn;
  logic [BW-1:0] pn;
  logic [BW-1:0] c;

  always_comb begin
    g0 = x & y;
    p0 = x ^ y;
    gg = g0;
    pp = p0;
    gg[0] = g0[0] | (p0[0] & cin);
    gn = gg;
    pn = pp;
    // Level k combines each span with the span 2**k positions below it.
    for (int k = 0; k < LV; k++) begin
      gn = gg;
      pn = pp;
      for (int i = 0; i < BW; i++) begin
        if (i >= (1 << k)) begin
          gn[i] = gg[i] | (pp[i] & gg[i - (1 << k)]);
          pn[i] = pp[i] & pp[i - (1 << k)];
        end
      end
      gg = gn;
      pp = pn;
    end
    // gg[i] is now the carry out of bit i; carry into bit i is gg[i-1].
    c    = {gg[BW-2:0], cin};
    s    = p0 ^ c;
    cout = gg[BW-1];
  end

endmodule

// File: rtl/ks_stream_subtractor.sv
// ks_stream_subtractor: streaming multi-word A - B, least-significant word
// first, borrow chained between words.
//   clk, resetn : clock (rising edge), asynchronous active-low reset
//   s           : stream interface (slave side), see ks_stream_subtractor_if
//   err         : sticky protocol error, cleared only by reset
//   state_dbg   : current operand FSM state
// Each word is computed as in_a + ~in_b + cin; the inverted carry out is the
// borrow into the next word. One registered output stage, latency 1.
module ks_stream_subtractor
  import ks_pkg::*;
#(
  parameter int BW = BW_DEFAULT
) (
  input  logic                      clk,
  input  logic                      resetn,
  ks_stream_subtractor_if.slave     s,
  output logic                      err,
  output state_t                    state_dbg
);

  state_t        state;
  logic          borrow_q;
  logic          zero_q;

  logic          accept;
  logic          first_word;
  logic          cin;
  logic [BW-1:0] d;
  logic          c;
  logic          zero_next;
  logic          ovf_word;
  logic          proto_err;

  // Output register can take a new word whenever it is empty or draining.
  assign s.in_ready = !s.out_valid | s.out_ready;
  assign accept     = s.in_valid & s.in_ready;

  // A stray non-first word in IDLE is still treated as the start of an operand.
  assign first_word = s.in_first | (state == S_IDLE);
  assign cin        = first_word ? 1'b1 : ~borrow_q;

  ks_prefix_add #(.BW(BW)) u_add (
    .x    (s.in_a),
    .y    (~s.in_b),
    .cin  (cin),
    .s    (d),
    .cout (c)
  );

  assign zero_next = (first_word ? 1'b1 : zero_q) & (d == '0);
  assign ovf_word  = (s.in_a[BW-1] ^ s.in_b[BW-1]) & (s.in_a[BW-1] ^ d[BW-1]);
  assign proto_err = ((state == S_IDLE) & ~s.in_first) |
                     ((state == S_BUSY) &  s.in_first);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state        <= S_IDLE;
      borrow_q     <= 1'b0;
      zero_q       <= 1'b0;
      err          <= 1'b0;
      s.out_valid  <= 1'b0;
      s.out_diff   <= '0;
      s.out_last   <= 1'b0;
      s.out_borrow <= 1'b0;
      s.out_ovf    <= 1'b0;
      s.out_zero   <= 1'b0;
    end else if (accept) begin
      borrow_q     <= ~c;
      zero_q       <= zero_next;
      if (proto_err) err <= 1'b1;
      s.out_valid  <= 1'b1;
      s.out_diff   <= d;
      s.out_last   <= s.in_last;
      s.out_borrow <= s.in_last & ~c;
      s.out_ovf    <= s.in_last & ovf_word;
      s.out_zero   <= s.in_last & zero_next;
      // A first word while BUSY restarts the chain but keeps the operand open.
      state        <= s.in_last ? S_IDLE : S_BUSY;
    end else if (s.out_ready) begin
      s.out_valid  <= 1'b0;
    end
  end

  assign state_dbg = state;

endmodule
